// File: rtl/sensor_frontend.sv
// Sensor front end: synchronises and debounces four contact sensors, and periodically
// reads a 7-bit serial temperature ADC with a timeout guard.
module sensor_frontend #(
    parameter int unsigned DEB_CYCLES    = 4,
    parameter int unsigned SAMPLE_PERIOD = 1000,
    parameter int unsigned ADC_TIMEOUT   = 64
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic       raw_fd,
    input  logic       raw_rd,
    input  logic       raw_w,
    input  logic       raw_fa,
    output logic       adc_start,
    input  logic       adc_done,
    input  logic       adc_sdata,
    output logic       SFD,
    output logic       SRD,
    output logic       SW,
    output logic       SFA,
    output logic [6:0] ST,
    output logic       st_valid,
    output logic       adc_err
);

    localparam logic [7:0]  DEB_MAX = 8'(DEB_CYCLES - 1);
    localparam logic [7:0]  TO_MAX  = 8'(ADC_TIMEOUT - 1);
    localparam logic [15:0] PER_MAX = 16'(SAMPLE_PERIOD - 1);

    typedef enum logic [2:0] {StIdle, StStart, StWait, StShift, StUpdate} adc_state_e;

    logic [3:0]  raw;
    logic [3:0]  sync1;
    logic [3:0]  sync2;
    logic [3:0]  deb;
    logic [7:0]  deb_cnt [4];
    logic [15:0] per_cnt;
    logic        tick;
    adc_state_e  state;
    logic [7:0]  to_cnt;
    logic [2:0]  bit_cnt;
    logic [6:0]  shreg;

    assign raw = {raw_fa, raw_w, raw_rd, raw_fd};
    assign {SFA, SW, SRD, SFD} = deb;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Counter tracks how long the synchronised input has disagreed with the output.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            deb <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_MAX) begin
                        deb[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 8'd1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            per_cnt <= '0;
        end else if (per_cnt == PER_MAX) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 16'd1;
        end
    end

    assign tick = (per_cnt == PER_MAX);

    // ST and st_valid are set on the last SHIFT edge so both are visible during UPDATE.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state     <= StIdle;
            adc_start <= 1'b0;
            adc_err   <= 1'b0;
            ST        <= '0;
            st_valid  <= 1'b0;
            to_cnt    <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
        end else begin
            adc_start <= 1'b0;
            st_valid  <= 1'b0;
            case (state)
                StIdle: begin
                    if (tick) begin
                        state     <= StStart;
                        adc_start <= 1'b1;
                    end
                end
                StStart: begin
                    state  <= StWait;
                    to_cnt <= '0;
                end
                StWait: begin
                    if (adc_done) begin
                        state   <= StShift;
                        bit_cnt <= '0;
                    end else if (to_cnt == TO_MAX) begin
                        state   <= StIdle;
                        adc_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                StShift: begin
                    shreg <= {shreg[5:0], adc_sdata};
                    if (bit_cnt == 3'd6) begin
                        state    <= StUpdate;
                        ST       <= {shreg[5:0], adc_sdata};
                        st_valid <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                StUpdate: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_frontend.sv
// Directed bench for sensor_frontend: debounce latency/glitch rejection, ADC capture,
// timeout, mid-conversion reset and tick dropping on a long conversion.
module tb_sensor_frontend;

    logic clk = 1'b0;
    logic rst;
    logic raw_fd, raw_rd, raw_w, raw_fa;
    logic adc_start, adc_done, adc_sdata;
    logic sfd, srd, sw, sfa;
    logic [6:0] st;
    logic st_valid, adc_err;
    logic adc_start_l, adc_done_l, adc_sdata_l;
    logic sfd_l, srd_l, sw_l, sfa_l;
    logic [6:0] st_l;
    logic st_valid_l, adc_err_l;

    int n_cmp = 0;
    int n_mis = 0;
    int starts_l = 0;
    int n;
    int s0;

    always #5 clk = ~clk;

    sensor_frontend #(.DEB_CYCLES(4), .SAMPLE_PERIOD(16), .ADC_TIMEOUT(8)) dut (
        .clk(clk), .Rst(rst),
        .raw_fd(raw_fd), .raw_rd(raw_rd), .raw_w(raw_w), .raw_fa(raw_fa),
        .adc_start(adc_start), .adc_done(adc_done), .adc_sdata(adc_sdata),
        .SFD(sfd), .SRD(srd), .SW(sw), .SFA(sfa),
        .ST(st), .st_valid(st_valid), .adc_err(adc_err)
    );

    // Longer timeout so a conversion can outlast one sample period.
    sensor_frontend #(.DEB_CYCLES(4), .SAMPLE_PERIOD(16), .ADC_TIMEOUT(16)) dut_l (
        .clk(clk), .Rst(rst),
        .raw_fd(raw_fd), .raw_rd(raw_rd), .raw_w(raw_w), .raw_fa(raw_fa),
        .adc_start(adc_start_l), .adc_done(adc_done_l), .adc_sdata(adc_sdata_l),
        .SFD(sfd_l), .SRD(srd_l), .SW(sw_l), .SFA(sfa_l),
        .ST(st_l), .st_valid(st_valid_l), .adc_err(adc_err_l)
    );

    always @(posedge clk) if (adc_start_l === 1'b1) starts_l++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input bit which, output int cnt);
        cnt = 0;
        while (cnt < 40 && !(which ? adc_start_l : adc_start)) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    // Called in the cycle adc_start is seen; returns in the UPDATE cycle.
    task automatic run_conv(input bit which, input int done_at, input logic [6:0] word);
        @(negedge clk);
        check("start_one_cycle", which ? adc_start_l : adc_start, 0);
        repeat (done_at - 1) @(negedge clk);
        if (which) adc_done_l = 1'b1; else adc_done = 1'b1;
        @(negedge clk);
        adc_done   = 1'b0;
        adc_done_l = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            if (which) adc_sdata_l = word[i]; else adc_sdata = word[i];
            @(negedge clk);
        end
        adc_sdata   = 1'b0;
        adc_sdata_l = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {raw_fd, raw_rd, raw_w, raw_fa} = '0;
        {adc_done, adc_sdata, adc_done_l, adc_sdata_l} = '0;
        repeat (3) @(negedge clk);
        check("rst_sfd", sfd, 0);
        check("rst_srd", srd, 0);
        check("rst_sw", sw, 0);
        check("rst_sfa", sfa, 0);
        check("rst_st", st, 0);
        check("rst_st_valid", st_valid, 0);
        check("rst_adc_start", adc_start, 0);
        check("rst_adc_err", adc_err, 0);
        rst = 1'b0;

        raw_fd = 1'b1;
        repeat (5) @(negedge clk);
        check("sfd_edge5", sfd, 0);
        @(negedge clk);
        check("sfd_edge6", sfd, 1);
        check("srd_quiet", srd, 0);
        check("sw_quiet", sw, 0);
        check("sfa_quiet", sfa, 0);

        raw_w = 1'b1;
        repeat (3) @(negedge clk);
        raw_w = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("sw_glitch", sw, 0);
        end

        raw_rd = 1'b1;
        raw_fa = 1'b1;
        repeat (5) @(negedge clk);
        check("srd_edge5", srd, 0);
        check("sfa_edge5", sfa, 0);
        @(negedge clk);
        check("srd_edge6", srd, 1);
        check("sfa_edge6", sfa, 1);

        // Fresh reset so the ADC checks start from a known period phase.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_start(1'b0, n);
        check("first_start_after_rst", n, 16);
        run_conv(1'b0, 3, 7'b1010011);
        check("st_word", st, 7'h53);
        check("st_valid_pulse", st_valid, 1);
        @(negedge clk);
        check("st_valid_drop", st_valid, 0);
        check("st_hold", st, 7'h53);
        wait_start(1'b0, n);
        check("period_16", 12 + n, 16);

        repeat (8) @(negedge clk);
        check("err_before_timeout", adc_err, 0);
        @(negedge clk);
        check("err_after_timeout", adc_err, 1);
        check("st_kept_timeout", st, 7'h53);
        check("no_valid_timeout", st_valid, 0);
        wait_start(1'b0, n);
        check("period_after_timeout", 9 + n, 16);
        run_conv(1'b0, 3, 7'h2C);
        check("st_after_timeout", st, 7'h2C);
        check("valid_after_timeout", st_valid, 1);
        check("err_sticky", adc_err, 1);

        @(negedge clk);
        wait_start(1'b0, n);
        repeat (3) @(negedge clk);
        adc_done = 1'b1;
        @(negedge clk);
        adc_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            adc_sdata = 1'b1;
            @(negedge clk);
        end
        adc_sdata = 1'b0;
        rst = 1'b1;
        #1;
        check("async_st", st, 0);
        check("async_st_valid", st_valid, 0);
        check("async_err", adc_err, 0);
        check("async_sfd", sfd, 0);
        check("async_sfa", sfa, 0);
        check("async_adc_start", adc_start, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_start(1'b0, n);
        check("start_after_mid_rst", n, 16);
        check("st_zero_before_conv", st, 0);
        run_conv(1'b0, 3, 7'h7F);
        check("st_fresh_word", st, 7'h7F);
        check("valid_fresh_word", st_valid, 1);

        wait_start(1'b1, n);
        check("long_start_seen", adc_start_l, 1);
        s0 = starts_l;
        run_conv(1'b1, 12, 7'h35);
        check("long_st", st_l, 7'h35);
        check("long_valid", st_valid_l, 1);
        wait_start(1'b1, n);
        check("long_next_start", 20 + n, 32);
        check("long_one_start", starts_l - s0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/sensor_frontend.md
SENSOR_FRONTEND -- requirements
Module: sensor_frontend

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable cycles required before a debounced door/window/alarm output changes (range 2..255).
REQ-002 Parameter SAMPLE_PERIOD, default 1000: cycles between temperature conversion requests (range 16..65535).
REQ-003 Parameter ADC_TIMEOUT, default 64: maximum cycles to wait for adc_done after adc_start (range 2..255).
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 Rst  input  1  reset, asynchronous and active-high.
REQ-006 raw_fd  input  1  front-door sensor, asynchronous, unfiltered.
REQ-007 raw_rd  input  1  rear-door sensor, asynchronous, unfiltered.
REQ-008 raw_w  input  1  window sensor, asynchronous, unfiltered.
REQ-009 raw_fa  input  1  fire-alarm sensor, asynchronous, unfiltered.
REQ-010 adc_start  output  1  one-cycle conversion request to the temperature ADC.
REQ-011 adc_done  input  1  ADC conversion complete; serial data follows starting the next cycle.
REQ-012 adc_sdata  input  1  ADC serial temperature data, MSB first, one bit per cycle.
REQ-013 SFD, SRD, SW, SFA  output  1 each  debounced raw_fd, raw_rd, raw_w, raw_fa; feed the home controller sensor inputs directly.
REQ-014 ST  output  7  last valid temperature word, unsigned.
REQ-015 st_valid  output  1  one-cycle pulse when ST is updated.
REQ-016 adc_err  output  1  sticky flag, set on ADC timeout, cleared only by Rst.

Function
REQ-017 Each raw input SHALL pass through a two-flop synchronizer before any other use.
REQ-018 Per channel, a counter SHALL increment each cycle the synchronized value differs from the debounced output, and clear to 0 on any cycle they are equal.
REQ-019 The debounced output SHALL take the synchronized value on the edge where the difference has persisted DEB_CYCLES consecutive cycles; the counter clears on that same edge.
REQ-020 Latency from a stable raw change to the output change SHALL be exactly 2 + DEB_CYCLES clock edges; any glitch shorter than DEB_CYCLES synchronized cycles produces no output change.
REQ-021 The four debounce channels SHALL be fully independent; simultaneous changes produce simultaneous output updates.
REQ-022 A period counter SHALL run continuously from 0 to SAMPLE_PERIOD-1 and wrap to 0; its terminal count is the sample tick.
REQ-023 The ADC FSM SHALL have states IDLE, START, WAIT, SHIFT, UPDATE.
REQ-024 IDLE -> START on sample tick; a tick arriving in any other state SHALL be dropped (not queued).
REQ-025 START: adc_start = 1 for exactly this one cycle; next state WAIT with the timeout counter cleared.
REQ-026 WAIT -> SHIFT when adc_done = 1; adc_done during IDLE, START, SHIFT or UPDATE SHALL be ignored.
REQ-027 WAIT -> IDLE with adc_err set when ADC_TIMEOUT cycles elapse without adc_done; ST and st_valid are unchanged.
REQ-028 SHIFT SHALL capture adc_sdata for exactly 7 consecutive cycles into a shift register, first bit becoming ST[6]; then go to UPDATE.
REQ-029 UPDATE SHALL load ST from the shift register, pulse st_valid for this one cycle, and return to IDLE.
REQ-030 ST SHALL hold its value at all times except the UPDATE load; adc_err does not block later conversions.

Reset
REQ-031 While Rst = 1: SFD, SRD, SW, SFA, ST, st_valid, adc_start, adc_err = 0; synchronizers, debounce counters, period counter, timeout counter and shift register = 0; FSM = IDLE.
REQ-032 Rst asserted mid-conversion SHALL discard partial data; the first request after release occurs at period count SAMPLE_PERIOD-1.

Verification
REQ-033 Reset then raw_fd 0->1 held, DEB_CYCLES=4 -> SFD rises exactly 6 edges later; other outputs stay 0.
REQ-034 raw_w pulse of 3 synchronized cycles, DEB_CYCLES=4 -> SW stays 0; raw_rd and raw_fa rising on the same cycle -> SRD and SFA rise on the same edge.
REQ-035 SAMPLE_PERIOD=16, adc_done 3 cycles after adc_start, then serial 1010011 -> ST = 7'h53, st_valid one cycle, next adc_start 16 cycles after the previous.
REQ-036 adc_done never asserted, ADC_TIMEOUT=8 -> adc_err = 1 after 8 WAIT cycles, ST unchanged, next conversion succeeds with adc_err still 1.
REQ-037 Rst asserted after 3 SHIFT bits -> all outputs 0 asynchronously, no st_valid; after release the next conversion loads a fresh full word.
REQ-038 Long conversion spanning a sample tick (SAMPLE_PERIOD=16, adc_done at WAIT cycle 12) -> exactly one adc_start per conversion, tick dropped, no back-to-back request.
